ff_bank_multimode: RTL

//   WIDTH-bit bank of clocked flip-flops with a runtime-selectable mode: D, T, JK or SR.
//   It replaces single-bit SR/JK cells wherever a register's behaviour changes with configuration.
//   The SR S=R=1 case has a deterministic policy, not 'x'.

---
 rtl/ff_bank_multimode_if.sv | 33 +++
 rtl/ff_bank_multimode.sv | 139 +++++++++++++
 2 files changed

// File: rtl/ff_bank_multimode_if.sv
// Bus bundle for ff_bank_multimode: control/data inputs and state/status outputs.
interface ff_bank_multimode_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) ();

  logic             en;
  logic [1:0]       mode_in;
  logic             mode_load;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clr_err;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [1:0]       mode;
  logic             err_sr;
  logic [CNT_W-1:0] err_cnt;
  logic             err_sticky;

  // Driver side: owns the controls and per-bit inputs, observes state/status.
  modport master (
    output en, mode_in, mode_load, a, b, clr_err,
    input  q, qn, mode, err_sr, err_cnt, err_sticky
  );

  // Flip-flop bank side.
  modport slave (
    input  en, mode_in, mode_load, a, b, clr_err,
    output q, qn, mode, err_sr, err_cnt, err_sticky
  );

endinterface

// File: rtl/ff_bank_multimode.sv
// WIDTH-bit flip-flop bank with a runtime mode (D/T/JK/SR), deterministic SR S=R=1
// handling and illegal-SR status (pulse, saturating counter, sticky flag).
module ff_bank_multimode #(
  parameter int unsigned     WIDTH       = 8,
  parameter logic [WIDTH-1:0] INIT       = '0,
  parameter int unsigned     SR11_POLICY = 0,
  parameter int unsigned     CNT_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  ff_bank_multimode_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_JK = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_qn;
  mode_e            r_mode;
  logic             r_err_sr;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_err_sticky;

  logic             w_update;
  logic             w_illegal;
  logic [WIDTH-1:0] w_sr11;
  logic [WIDTH-1:0] w_q_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_sticky_next;

  // An update edge is an enabled edge that is not spent loading the mode.
  assign w_update  = bus.en & ~bus.mode_load;
  // One illegal event per edge no matter how many bits collide.
  assign w_illegal = w_update & (r_mode == MODE_SR) & (|(bus.a & bus.b));

  // Next value of every bit for the SR S=R=1 case, fixed at elaboration.
  always_comb begin
    w_sr11 = r_q;
    case (SR11_POLICY)
      32'd1:   w_sr11 = '1;
      32'd2:   w_sr11 = '0;
      32'd3:   w_sr11 = ~r_q;
      default: w_sr11 = r_q;
    endcase
  end

  // Per-bit next state for the active mode; holds unless this is an update edge.
  always_comb begin
    w_q_next = r_q;
    if (w_update) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        case (r_mode)
          MODE_D:  w_q_next[i] = bus.a[i];
          MODE_T:  w_q_next[i] = r_q[i] ^ bus.a[i];
          MODE_JK: begin
            case ({bus.a[i], bus.b[i]})
              2'b01:   w_q_next[i] = 1'b0;
              2'b10:   w_q_next[i] = 1'b1;
              2'b11:   w_q_next[i] = ~r_q[i];
              default: w_q_next[i] = r_q[i];
            endcase
          end
          default: begin
            case ({bus.a[i], bus.b[i]})
              2'b01:   w_q_next[i] = 1'b0;
              2'b10:   w_q_next[i] = 1'b1;
              2'b11:   w_q_next[i] = w_sr11[i];
              default: w_q_next[i] = r_q[i];
            endcase
          end
        endcase
      end
    end
  end

  // Status next state: an illegal event beats a simultaneous clear.
  always_comb begin
    w_cnt_next    = r_err_cnt;
    w_sticky_next = r_err_sticky;
    if (w_illegal) begin
      w_sticky_next = 1'b1;
      if (bus.clr_err) begin
        w_cnt_next = CNT_W'(1);
      end else if (r_err_cnt != CNT_MAX) begin
        w_cnt_next = r_err_cnt + CNT_W'(1);
      end
    end else if (bus.clr_err) begin
      w_cnt_next    = '0;
      w_sticky_next = 1'b0;
    end
  end

  // Flip-flop state and its complement, reset to INIT / ~INIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q  <= INIT;
      r_qn <= ~INIT;
    end else begin
      r_q  <= w_q_next;
      r_qn <= ~w_q_next;
    end
  end

  // Mode register; a newly loaded mode takes effect from the following edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= MODE_JK;
    end else if (bus.mode_load) begin
      r_mode <= mode_e'(bus.mode_in);
    end
  end

  // Illegal-SR status: one-cycle pulse, saturating counter, sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_sr     <= 1'b0;
      r_err_cnt    <= '0;
      r_err_sticky <= 1'b0;
    end else begin
      r_err_sr     <= w_illegal;
      r_err_cnt    <= w_cnt_next;
      r_err_sticky <= w_sticky_next;
    end
  end

  assign bus.q          = r_q;
  assign bus.qn         = r_qn;
  assign bus.mode       = r_mode;
  assign bus.err_sr     = r_err_sr;
  assign bus.err_cnt    = r_err_cnt;
  assign bus.err_sticky = r_err_sticky;

endmodule
